// File: rtl/gd_param_update_if.sv
// Evaluator-side bus of the gradient-descent controller: parameters out, result and
// completion back.
// Handshake: start_func is a level request held until func_done is seen high; the
// controller then drops start_func and waits for func_done to return low, and a..d_out
// stay constant for as long as start_func is high.
interface gd_param_update_if;
   logic [15:0] a_out;
   logic [15:0] b_out;
   logic [15:0] c_out;
   logic [15:0] d_out;
   logic        start_func;
   logic        func_done;
   logic [31:0] z_in;

   modport master (
      output a_out, b_out, c_out, d_out, start_func,
      input  func_done, z_in
   );

   modport slave (
      input  a_out, b_out, c_out, d_out, start_func,
      output func_done, z_in
   );
endinterface

// File: rtl/gd_param_update.sv
// Gradient-descent controller for f = (a-2)^2 + (c+2)^2 + (5d)^2 + (b^2 - 5) over four
// Q8.8 parameters, driving an external function evaluator through gd_param_update_if.
module gd_param_update #(
   parameter int          LR_SHIFT = 6,
   parameter int          MAX_ITER = 255,
   parameter int          ITER_W   = 8,
   parameter logic [31:0] TOL      = 32'd1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [15:0]           a_init,
   input  logic [15:0]           b_init,
   input  logic [15:0]           c_init,
   input  logic [15:0]           d_init,
   gd_param_update_if.master     ev,
   output logic [31:0]           z_final,
   output logic [ITER_W-1:0]     iter_count,
   output logic                  busy,
   output logic                  done,
   output logic                  converged,
   output logic                  sat_flag,
   output logic [2:0]            fsm_state
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_EVAL    = 3'd1;
   localparam logic [2:0] S_RELEASE = 3'd2;
   localparam logic [2:0] S_CHECK   = 3'd3;
   localparam logic [2:0] S_UPDATE  = 3'd4;
   localparam logic [2:0] S_DONE    = 3'd5;

   localparam logic [ITER_W-1:0] MAX_CNT = ITER_W'(MAX_ITER);

   logic [2:0]         state;
   logic [15:0]        a_q, b_q, c_q, d_q;
   logic [31:0]        z_prev;

   logic signed [31:0] a_x, b_x, c_x, d_x;
   logic signed [31:0] ga, gb, gc, gd;
   logic [16:0]        a_n, b_n, c_n, d_n;
   logic signed [32:0] z_diff;
   logic [32:0]        z_mag;
   logic               any_clip;

   // {clipped, value}: clamp a 32-bit signed result into the Q8.8 range
   function automatic logic [16:0] clip16(input logic signed [31:0] v);
      if (v > 32'sd32767)
         return {1'b1, 16'h7FFF};
      else if (v < -32'sd32768)
         return {1'b1, 16'h8000};
      else
         return {1'b0, v[15:0]};
   endfunction

   always_comb begin
      a_x = {{16{a_q[15]}}, a_q};
      b_x = {{16{b_q[15]}}, b_q};
      c_x = {{16{c_q[15]}}, c_q};
      d_x = {{16{d_q[15]}}, d_q};
      ga  = (a_x - 32'sd512) <<< 1;
      gb  = b_x <<< 1;
      gc  = (c_x + 32'sd512) <<< 1;
      // 50*d built from shifts: 32 + 16 + 2
      gd  = (d_x <<< 5) + (d_x <<< 4) + (d_x <<< 1);
      a_n = clip16(a_x - (ga >>> LR_SHIFT));
      b_n = clip16(b_x - (gb >>> LR_SHIFT));
      c_n = clip16(c_x - (gc >>> LR_SHIFT));
      d_n = clip16(d_x - (gd >>> LR_SHIFT));
      any_clip = a_n[16] | b_n[16] | c_n[16] | d_n[16];
   end

   // 33-bit difference so opposite-sign extremes cannot wrap
   always_comb begin
      z_diff = {z_final[31], z_final} - {z_prev[31], z_prev};
      z_mag  = z_diff[32] ? (~z_diff + 33'd1) : z_diff;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         a_q        <= '0;
         b_q        <= '0;
         c_q        <= '0;
         d_q        <= '0;
         z_final    <= '0;
         z_prev     <= '0;
         iter_count <= '0;
         converged  <= 1'b0;
         sat_flag   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  a_q        <= a_init;
                  b_q        <= b_init;
                  c_q        <= c_init;
                  d_q        <= d_init;
                  iter_count <= '0;
                  converged  <= 1'b0;
                  sat_flag   <= 1'b0;
                  state      <= S_EVAL;
               end
            end
            S_EVAL: begin
               if (ev.func_done) begin
                  z_final <= ev.z_in;
                  state   <= S_RELEASE;
               end
            end
            S_RELEASE: begin
               if (!ev.func_done) state <= S_CHECK;
            end
            S_CHECK: begin
               if ((iter_count != '0) && (z_mag <= {1'b0, TOL})) begin
                  converged <= 1'b1;
                  state     <= S_DONE;
               end else if (iter_count == MAX_CNT) begin
                  converged <= 1'b0;
                  state     <= S_DONE;
               end else begin
                  state <= S_UPDATE;
               end
            end
            S_UPDATE: begin
               a_q        <= a_n[15:0];
               b_q        <= b_n[15:0];
               c_q        <= c_n[15:0];
               d_q        <= d_n[15:0];
               sat_flag   <= sat_flag | any_clip;
               z_prev     <= z_final;
               iter_count <= iter_count + 1'b1;
               state      <= S_EVAL;
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Request and status are decoded from state so a reset drops them immediately
   assign ev.start_func = (state == S_EVAL);
   assign ev.a_out      = a_q;
   assign ev.b_out      = b_q;
   assign ev.c_out      = c_q;
   assign ev.d_out      = d_q;
   assign busy          = (state != S_IDLE);
   assign done          = (state == S_DONE);
   assign fsm_state     = state;

endmodule

// File: tb/tb_gd_param_update.sv
// Bench for gd_param_update: four differently parameterised instances, each with a
// randomly delayed evaluator, checked against a whole-run arithmetic model.
`timescale 1ns/1ps
module tb_gd_param_update;
   localparam int N = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        start_s [N];
   logic [15:0] a_i [N], b_i [N], c_i [N], d_i [N];
   logic [15:0] a_o [N], b_o [N], c_o [N], d_o [N];
   logic        sf_o [N];
   logic [31:0] zf_o [N];
   logic [7:0]  it_o [N];
   logic        busy_o [N], done_o [N], conv_o [N], sat_o [N];
   logic [2:0]  st_o [N];
   int          evals_a [N], bad_stable_a [N], bad_hs_a [N], nonmono_a [N];
   int          max_delay;
   int          errors = 0;
   int          checks = 0;

   function automatic int lr_of(input int g);
      return (g == 2) ? 0 : 6;
   endfunction
   function automatic int maxit_of(input int g);
      return (g == 0) ? 255 : (g == 3) ? 4 : 1;
   endfunction
   function automatic longint tol_of(input int g);
      return (g == 3) ? 0 : 1;
   endfunction

   // Ideal evaluator: f in Q24.8 from Q8.8 parameters
   function automatic longint ideal_z(input logic [15:0] a, b, c, d);
      longint sa, sb, sc, sd, s;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sc = longint'($signed(c));
      sd = longint'($signed(d));
      s  = (sa - 512) * (sa - 512) + sb * sb + (sc + 512) * (sc + 512) + 25 * sd * sd;
      return s / 256 - 1280;
   endfunction

   function automatic longint floor_div(input longint x, input longint dv);
      longint q;
      q = x / dv;
      if ((x % dv != 0) && (x < 0)) q = q - 1;
      return q;
   endfunction

   // Whole-run model: evaluate, test convergence, gradient step with clamping
   task automatic ref_run(input int lr, input int maxit, input longint tol,
                          input logic [15:0] ia, ib, ic, id,
                          output logic [15:0] oa, ob, oc, od, output logic [31:0] oz,
                          output int oit, output bit oconv, output bit osat);
      longint p [4];
      longint gr [4];
      longint z, zp, np, dz;
      int     it;
      p[0] = longint'($signed(ia));
      p[1] = longint'($signed(ib));
      p[2] = longint'($signed(ic));
      p[3] = longint'($signed(id));
      it = 0; zp = 0; osat = 0; oconv = 0;
      forever begin
         z  = ideal_z(p[0][15:0], p[1][15:0], p[2][15:0], p[3][15:0]);
         dz = (z > zp) ? z - zp : zp - z;
         if (it != 0 && dz <= tol) begin oconv = 1; break; end
         if (it == maxit) begin oconv = 0; break; end
         gr[0] = 2 * (p[0] - 512);
         gr[1] = 2 * p[1];
         gr[2] = 2 * (p[2] + 512);
         gr[3] = 50 * p[3];
         for (int k = 0; k < 4; k++) begin
            np = p[k] - floor_div(gr[k], longint'(1) << lr);
            if (np > 32767) begin np = 32767; osat = 1; end
            if (np < -32768) begin np = -32768; osat = 1; end
            p[k] = np;
         end
         zp = z;
         it++;
      end
      oa = p[0][15:0]; ob = p[1][15:0]; oc = p[2][15:0]; od = p[3][15:0];
      oz = z[31:0]; oit = it;
   endtask

   for (genvar g = 0; g < N; g++) begin : gen_dut
      gd_param_update_if ev_if ();
      logic        fd_l = 1'b0;
      logic [31:0] z_l = '0;
      int          evals_l = 0, bad_stable_l = 0, bad_hs_l = 0, nonmono_l = 0;
      int          delay_l = 0, hold_l = 0;
      bit          armed_l = 0;
      logic        prev_sf = 1'b0, prev_fd = 1'b0;
      logic [63:0] prev_p = '0, cur_p;
      longint      last_z = 0, zv;

      assign ev_if.func_done = fd_l;
      assign ev_if.z_in      = z_l;
      assign a_o[g]          = ev_if.a_out;
      assign b_o[g]          = ev_if.b_out;
      assign c_o[g]          = ev_if.c_out;
      assign d_o[g]          = ev_if.d_out;
      assign sf_o[g]         = ev_if.start_func;
      assign evals_a[g]      = evals_l;
      assign bad_stable_a[g] = bad_stable_l;
      assign bad_hs_a[g]     = bad_hs_l;
      assign nonmono_a[g]    = nonmono_l;

      gd_param_update #(
         .LR_SHIFT (lr_of(g)),
         .MAX_ITER (maxit_of(g)),
         .ITER_W   (8),
         .TOL      ((g == 3) ? 32'd0 : 32'd1)
      ) u_dut (
         .clk        (clk),
         .rst_n      (rst_n),
         .start      (start_s[g]),
         .a_init     (a_i[g]),
         .b_init     (b_i[g]),
         .c_init     (c_i[g]),
         .d_init     (d_i[g]),
         .ev         (ev_if.master),
         .z_final    (zf_o[g]),
         .iter_count (it_o[g]),
         .busy       (busy_o[g]),
         .done       (done_o[g]),
         .converged  (conv_o[g]),
         .sat_flag   (sat_o[g]),
         .fsm_state  (st_o[g])
      );

      // Evaluator: random latency, holds func_done a few cycles after start_func drops
      always @(negedge clk) begin
         if (!rst_n) begin
            fd_l = 1'b0; armed_l = 0; hold_l = 0; prev_sf = 1'b0; prev_fd = 1'b0;
         end else begin
            cur_p = {ev_if.a_out, ev_if.b_out, ev_if.c_out, ev_if.d_out};
            if (ev_if.start_func && prev_sf && cur_p != prev_p) bad_stable_l++;
            if (!ev_if.start_func && prev_sf && !prev_fd) bad_hs_l++;
            prev_sf = ev_if.start_func;
            prev_p  = cur_p;
            if (fd_l) begin
               if (!ev_if.start_func) begin
                  if (hold_l == 0) fd_l = 1'b0;
                  else hold_l--;
               end
            end else if (ev_if.start_func) begin
               if (!armed_l) begin
                  delay_l = $urandom_range(0, max_delay);
                  armed_l = 1;
               end
               if (delay_l == 0) begin
                  zv = ideal_z(ev_if.a_out, ev_if.b_out, ev_if.c_out, ev_if.d_out);
                  z_l = zv[31:0];
                  fd_l = 1'b1;
                  hold_l = 2;
                  armed_l = 0;
                  evals_l++;
                  if (evals_l > 1 && zv >= last_z) nonmono_l++;
                  last_z = zv;
               end else begin
                  delay_l--;
               end
            end
            prev_fd = fd_l;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic run(input int g, input logic [15:0] a, b, c, d, input bit poke,
                      input string tag);
      logic [15:0] ea, eb, ec, ed;
      logic [31:0] ez;
      int          eit, ev0;
      bit          econv, esat, seen;
      ref_run(lr_of(g), maxit_of(g), tol_of(g), a, b, c, d,
              ea, eb, ec, ed, ez, eit, econv, esat);
      ev0 = evals_a[g];
      a_i[g] = a; b_i[g] = b; c_i[g] = c; d_i[g] = d;
      start_s[g] = 1'b1;
      @(posedge clk); #1;
      start_s[g] = 1'b0;
      a_i[g] = 16'($urandom); b_i[g] = 16'($urandom);
      c_i[g] = 16'($urandom); d_i[g] = 16'($urandom);
      chk({tag, "_busy"}, 32'(busy_o[g]), 32'd1);
      seen = 0;
      for (int cyc = 0; cyc < 8000 && !seen; cyc++) begin
         start_s[g] = (poke && $urandom_range(0, 15) == 0) ? 1'b1 : 1'b0;
         @(posedge clk); #1;
         if (done_o[g]) seen = 1;
      end
      start_s[g] = 1'b0;
      chk({tag, "_done_seen"}, 32'(seen), 32'd1);
      chk({tag, "_a"}, 32'(a_o[g]), 32'(ea));
      chk({tag, "_b"}, 32'(b_o[g]), 32'(eb));
      chk({tag, "_c"}, 32'(c_o[g]), 32'(ec));
      chk({tag, "_d"}, 32'(d_o[g]), 32'(ed));
      chk({tag, "_z"}, zf_o[g], ez);
      chk({tag, "_iter"}, 32'(it_o[g]), 32'(eit));
      chk({tag, "_conv"}, 32'(conv_o[g]), 32'(econv));
      chk({tag, "_sat"}, 32'(sat_o[g]), 32'(esat));
      chk({tag, "_evals"}, 32'(evals_a[g] - ev0), 32'(eit + 1));
      chk({tag, "_stable"}, 32'(bad_stable_a[g]), 32'd0);
      chk({tag, "_hshake"}, 32'(bad_hs_a[g]), 32'd0);
      @(posedge clk); #1;
      chk({tag, "_done_pulse"}, 32'(done_o[g]), 32'd0);
      chk({tag, "_idle"}, 32'(busy_o[g]), 32'd0);
      chk({tag, "_hold_a"}, 32'(a_o[g]), 32'(ea));
   endtask

   initial begin
      bit seen;
      rst_n = 1'b0;
      max_delay = 3;
      for (int i = 0; i < N; i++) begin
         start_s[i] = 1'b0;
         a_i[i] = '0; b_i[i] = '0; c_i[i] = '0; d_i[i] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("rst_a", 32'(a_o[0]), 32'd0);
      chk("rst_sf", 32'(sf_o[0]), 32'd0);
      chk("rst_busy", 32'(busy_o[0]), 32'd0);
      chk("rst_z", zf_o[0], 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run(0, 16'h0200, 16'h0000, 16'hFE00, 16'h0000, 0, "opt");
      chk("opt_z_const", zf_o[0], 32'hFFFFFB00);
      chk("opt_iter_const", 32'(it_o[0]), 32'd1);
      chk("opt_conv_const", 32'(conv_o[0]), 32'd1);

      run(1, 16'h0400, 16'h0000, 16'hFE00, 16'h0100, 0, "step");
      chk("step_a_const", 32'(a_o[1]), 32'h03F0);
      chk("step_d_const", 32'(d_o[1]), 32'h0038);
      chk("step_conv_const", 32'(conv_o[1]), 32'd0);

      run(2, 16'h0200, 16'h8000, 16'hFE00, 16'h0000, 0, "sat");
      chk("sat_b_const", 32'(b_o[2]), 32'h7FFF);
      chk("sat_flag_const", 32'(sat_o[2]), 32'd1);

      max_delay = 19;
      run(0, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1, "hs");
      max_delay = 3;

      run(3, 16'h7F00, 16'h0000, 16'hFE00, 16'h0000, 0, "cap");
      chk("cap_iter_const", 32'(it_o[3]), 32'd4);
      chk("cap_monotonic", 32'(nonmono_a[3]), 32'd0);

      // Reset in the middle of an evaluation request
      a_i[0] = 16'h1234; b_i[0] = 16'h0100; c_i[0] = 16'h0000; d_i[0] = 16'h0040;
      start_s[0] = 1'b1;
      @(posedge clk); #1;
      start_s[0] = 1'b0;
      seen = 0;
      for (int cyc = 0; cyc < 100 && !seen; cyc++) begin
         if (sf_o[0]) seen = 1;
         else begin @(posedge clk); #1; end
      end
      chk("mid_sf_seen", 32'(seen), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_sf", 32'(sf_o[0]), 32'd0);
      chk("mid_rst_a", 32'(a_o[0]), 32'd0);
      chk("mid_rst_d", 32'(d_o[0]), 32'd0);
      chk("mid_rst_busy", 32'(busy_o[0]), 32'd0);
      chk("mid_rst_iter", 32'(it_o[0]), 32'd0);
      chk("mid_rst_z", zf_o[0], 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      run(0, 16'h1234, 16'h0100, 16'h0000, 16'h0040, 0, "after_rst");

      for (int r = 0; r < 4; r++)
         run(0, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1, "rnd0");
      for (int r = 0; r < 3; r++)
         run(1, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1, "rnd1");
      for (int r = 0; r < 3; r++)
         run(2, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1, "rnd2");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
